hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised hazard and forwarding controller for the 5-stage pipeline, replacing the fixed two-port detector. It sits beside the ID stage and performs four jobs:
- computes per-read-port forwarding selects;
- detects load-use hazards;
- issues EX-stage redirect flushes;
- stalls the front end while a multi-cycle MUL/DIV op occupies EX, sequenced by an internal FSM and down-counter.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- RP, 2, number of ID register read ports (1..4)
- AW, 5, register address width
- MDU_LAT, 4, cycles an MDU op occupies EX (≥2)
- CW, 32, performance counter width

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- id_rR  in  RP*AW  packed ID read addresses, port i at [i*AW +: AW]
- id_rR_use  in  RP  port i actually reads a register
- ex_wR / mem_wR / wb_wR  in  AW  destination register per stage
- ex_we / mem_we / wb_we  in  1  stage writes RF
- ex_wsel / mem_wsel  in  2  writeback source; 2'd3 = DRAM (load)
- ex_is_mdu  in  1  EX holds a multi-cycle MUL/DIV op
- ex_npc_op  in  2  1 = jalr, 2 = jal; other values do not redirect
- ex_br_taken  in  1  conditional branch in EX taken
- perf_clr  in  1  synchronous clear of both counters
- fwd  out  RP*3  packed select per port: 0 RF, 1 EX, 2 MEM, 3 WB, 4 load-pending
- pc_stop, if_id_stop, id_ex_stop  out  1  hold register
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  insert bubble
- jump  out  2  0 none, 1 PC-relative target, 2 jalr target
- mdu_busy  out  1  MDU stall active this cycle
- stall_cnt, flush_cnt  out  CW  performance counters

## Operation
Forwarding, per port i, combinational:
- Check stages in the order EX, then MEM, then WB. The first stage that matches wins.
- A stage matches when we=1, wR≠0 and wR==rR[i].
- An EX or MEM match with wsel==3 gives select 4. Otherwise EX gives 1, MEM gives 2, WB gives 3.
- No match, or id_rR_use[i]=0, gives 0.

Control priority, highest first:
1. mdu_busy: pc_stop=if_id_stop=id_ex_stop=1, ex_mem_flush=1, all other flushes 0, jump=0.
2. Load-use: some port with use=1 matches EX with ex_wsel==3. Result: pc_stop=if_id_stop=1, id_ex_flush=1, jump=0.
3. ex_npc_op==1: if_id_flush=id_ex_flush=1, jump=2.
4. ex_npc_op==2 or ex_br_taken: if_id_flush=id_ex_flush=1, jump=1.
5. Otherwise all outputs 0.

MDU FSM (states IDLE, BUSY; counter cnt is ceil(log2(MDU_LAT)) bits):
- IDLE with ex_is_mdu=1: mdu_busy=1, cnt<=MDU_LAT-2, next state BUSY.
- BUSY with cnt≠0: mdu_busy=1, cnt<=cnt-1.
- BUSY with cnt==0: mdu_busy=0 (release cycle, op leaves EX), next state IDLE.
- Total stall is MDU_LAT-1 cycles. The op occupies EX for MDU_LAT cycles.
- Back-to-back MDU ops are handled: after the release, IDLE sees the new op.
- ex_is_mdu dropping while BUSY does not abort the sequence; the count completes.

Counters:
- stall_cnt increments every cycle pc_stop=1.
- flush_cnt increments every cycle jump≠0.
- Both saturate at all-ones.
- perf_clr has priority over increment.

## Timing
- Forwarding and control outputs are combinational from inputs and FSM state, with zero latency.
- While cpu_rst=1, every control output, fwd, jump and mdu_busy is forced to 0.
- Reset state: IDLE, cnt=0, stall_cnt=0, flush_cnt=0.
- Reset during BUSY aborts the sequence. The first cycle after deassertion is IDLE; if ex_is_mdu=1 then, a fresh MDU_LAT sequence starts.
- A redirect coinciding with mdu_busy is ignored, because MDU ops never redirect.
- Load-use and redirect in the same cycle resolve to load-use. The branch re-evaluates next cycle after the bubble.

## Test plan
- Forward priority: ex/mem/wb all write x5, ex_wsel=0, rR0=5 → fwd[2:0]=1. Drop ex_we → 2. Drop mem_we → 3. Set rR0=0 → 0.
- Load-use: ex_we=1, ex_wR=7, ex_wsel=3, rR1=7, use=1 → fwd port1=4, pc_stop=if_id_stop=id_ex_flush=1, jump=0. Repeat with use[1]=0 → no stall.
- Redirect: ex_npc_op=1 → jump=2, if_id_flush=id_ex_flush=1. ex_br_taken=1 with npc_op=0 → jump=1. After 3 such cycles, flush_cnt=3.
- MDU, MDU_LAT=4: hold ex_is_mdu=1 → mdu_busy high exactly 3 cycles, then low 1 cycle; stall_cnt=3. Keep ex_is_mdu=1 → the next sequence starts immediately.
- Reset mid-BUSY: assert cpu_rst on 2nd busy cycle → outputs 0 immediately, counters 0. Release with ex_is_mdu=1 → 3 fresh busy cycles.
- Saturation/clear, CW=4: 20 stall cycles → stall_cnt=15. perf_clr together with a stall → 0.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding selects, load-use/redirect/MDU hazard control and perf counters.
// Ports: cpu_clk/cpu_rst clock and async reset; id_rR/id_rR_use ID read ports;
// {ex,mem,wb}_{wR,we}, {ex,mem}_wsel producer info; ex_is_mdu, ex_npc_op, ex_br_taken EX status;
// perf_clr counter clear; fwd per-port selects; *_stop holds; *_flush bubbles; jump redirect kind;
// mdu_busy MDU stall; stall_cnt/flush_cnt saturating counters.
module hazard_unit_mc #(
  parameter int RP      = 2,
  parameter int AW      = 5,
  parameter int MDU_LAT = 4,
  parameter int CW      = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic [RP*AW-1:0] id_rR,
  input  logic [RP-1:0]    id_rR_use,
  input  logic [AW-1:0]    ex_wR,
  input  logic [AW-1:0]    mem_wR,
  input  logic [AW-1:0]    wb_wR,
  input  logic             ex_we,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic [1:0]       ex_wsel,
  input  logic [1:0]       mem_wsel,
  input  logic             ex_is_mdu,
  input  logic [1:0]       ex_npc_op,
  input  logic             ex_br_taken,
  input  logic             perf_clr,
  output logic [RP*3-1:0]  fwd,
  output logic             pc_stop,
  output logic             if_id_stop,
  output logic             id_ex_stop,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       jump,
  output logic             mdu_busy,
  output logic [CW-1:0]    stall_cnt,
  output logic [CW-1:0]    flush_cnt
);
  localparam int NW = $clog2(MDU_LAT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t          state, state_nx;
  logic [NW-1:0]   cnt, cnt_nx;
  logic            busy;
  logic [RP-1:0]   lu;
  logic            load_use;
  for (genvar g = 0; g < RP; g++) begin : g_port
    logic [AW-1:0] r;
    logic          ex_hit, mem_hit, wb_hit;
    assign r       = id_rR[g*AW +: AW];
    assign ex_hit  = ex_we  && ex_wR  != '0 && ex_wR  == r;
    assign mem_hit = mem_we && mem_wR != '0 && mem_wR == r;
    assign wb_hit  = wb_we  && wb_wR  != '0 && wb_wR  == r;
    assign lu[g]   = id_rR_use[g] && ex_hit && ex_wsel == 2'd3;
    assign fwd[g*3 +: 3] = (cpu_rst || !id_rR_use[g]) ? 3'd0 :
                           ex_hit  ? (ex_wsel  == 2'd3 ? 3'd4 : 3'd1) :
                           mem_hit ? (mem_wsel == 2'd3 ? 3'd4 : 3'd2) :
                           wb_hit  ? 3'd3 : 3'd0;
  end
  assign load_use = |lu;
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // The IDLE cycle that accepts the op already stalls, so BUSY counts down MDU_LAT-2 more
  // stall cycles and then spends one unstalled release cycle while the op leaves EX.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    if (state == IDLE) begin
      if (ex_is_mdu) begin
        busy     = 1'b1;
        cnt_nx   = NW'(MDU_LAT - 2);
        state_nx = BUSY;
      end
    end else if (cnt != '0) begin
      busy   = 1'b1;
      cnt_nx = cnt - 1'b1;
    end else begin
      state_nx = IDLE;
    end
  end
  assign mdu_busy = busy && !cpu_rst;
  always_comb begin
    pc_stop      = 1'b0;
    if_id_stop   = 1'b0;
    id_ex_stop   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    jump         = 2'd0;
    if (cpu_rst) begin
    end else if (mdu_busy) begin
      pc_stop      = 1'b1;
      if_id_stop   = 1'b1;
      id_ex_stop   = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_stop     = 1'b1;
      if_id_stop  = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_npc_op == 2'd1 || ex_npc_op == 2'd2 || ex_br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      jump        = ex_npc_op == 2'd1 ? 2'd2 : 2'd1;
    end
  end
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stop && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (jump != 2'd0 && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
